// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU opcodes, shift width.
package exec_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluNor  = 4'd5,
        AluSlt  = 4'd6,
        AluSltu = 4'd7,
        AluSll  = 4'd8,
        AluSrl  = 4'd9,
        AluSra  = 4'd10,
        AluLui  = 4'd11,
        AluRsv12 = 4'd12,
        AluRsv13 = 4'd13,
        AluRsv14 = 4'd14,
        AluRsv15 = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and zero/negative flags from two operands and an opcode.
module alu_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [3:0]      i_alu_op,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_negative
);
    import exec_pkg::*;

    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]    w_result;

    // Only the low bits of B are a shift amount; the rest are ignored.
    assign w_shamt = i_b[SHAMT_W-1:0];

    always_comb begin
        w_result = '0;
        case (alu_op_e'(i_alu_op))
            AluAdd:  w_result = i_a + i_b;
            AluSub:  w_result = i_a - i_b;
            AluAnd:  w_result = i_a & i_b;
            AluOr:   w_result = i_a | i_b;
            AluXor:  w_result = i_a ^ i_b;
            AluNor:  w_result = ~(i_a | i_b);
            AluSlt:  w_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            AluSltu: w_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            AluSll:  w_result = i_a << w_shamt;
            AluSrl:  w_result = i_a >> w_shamt;
            AluSra:  w_result = $unsigned($signed(i_a) >>> w_shamt);
            AluLui:  w_result = i_b << 16;
            default: w_result = '0;
        endcase
    end

    assign o_result   = w_result;
    assign o_zero     = (w_result == '0);
    assign o_negative = w_result[XLEN-1];

endmodule

// File: rtl/exec_unit.sv
// Execute stage: operand selection, ALU with one-cycle registered result and flags,
// plus combinational sequential-PC and branch-target adders.
module exec_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            in_valid,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic [15:0]     imm16,
    input  logic [4:0]      shamt,
    input  logic            alu_src,
    input  logic            is_unsigned,
    input  logic            use_shamt,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_incremented,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] result_q,
    output logic            zero_q,
    output logic            negative_q,
    output logic            out_valid
);
    import exec_pkg::*;

    logic [XLEN-1:0] w_imm_ext;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_result;
    logic            w_zero;
    logic            w_negative;
    logic [XLEN-1:0] w_branch_off;

    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_negative;
    logic            r_valid;

    assign w_imm_ext = is_unsigned ? {{(XLEN-16){1'b0}}, imm16}
                                   : {{(XLEN-16){imm16[15]}}, imm16};

    always_comb begin
        w_op_b = rt_data;
        if (use_shamt) begin
            w_op_b = {{(XLEN-SHAMT_W){1'b0}}, shamt};
        end else if (alu_src) begin
            w_op_b = w_imm_ext;
        end
    end

    alu_core #(
        .XLEN(XLEN)
    ) u_alu_core (
        .i_a       (rs_data),
        .i_b       (w_op_b),
        .i_alu_op  (alu_op),
        .o_result  (w_result),
        .o_zero    (w_zero),
        .o_negative(w_negative)
    );

    // Branch offset is always sign-extended, independent of is_unsigned.
    assign w_branch_off   = {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
    assign pc_incremented = pc + {{(XLEN-3){1'b0}}, 3'd4};
    assign branch_target  = pc_incremented + w_branch_off;

    // rst_b is active-high despite its name.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_result   <= w_result;
            r_zero     <= w_zero;
            r_negative <= w_negative;
            r_valid    <= in_valid;
        end
    end

    assign result_q   = r_result;
    assign zero_q     = r_zero;
    assign negative_q = r_negative;
    assign out_valid  = r_valid;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases plus randomized traffic vs a reference model.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        in_valid;
    logic [31:0] rs_data, rt_data, pc;
    logic [15:0] imm16;
    logic [4:0]  shamt;
    logic        alu_src, is_unsigned, use_shamt;
    logic [3:0]  alu_op;
    logic [31:0] pc_incremented, branch_target, result_q;
    logic        zero_q, negative_q, out_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_result;
    logic        exp_valid;

    exec_unit #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .in_valid      (in_valid),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .imm16         (imm16),
        .shamt         (shamt),
        .alu_src       (alu_src),
        .is_unsigned   (is_unsigned),
        .use_shamt     (use_shamt),
        .alu_op        (alu_op),
        .pc            (pc),
        .pc_incremented(pc_incremented),
        .branch_target (branch_target),
        .result_q      (result_q),
        .zero_q        (zero_q),
        .negative_q    (negative_q),
        .out_valid     (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model written from the opcode table with plain integer arithmetic.
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        int              s  = b % 32;
        logic [31:0]     r;
        case (op)
            0:  r = 32'((ua + ub) % 64'h1_0000_0000);
            1:  r = 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = ~(a | b);
            6:  r = (sa < sb) ? 32'd1 : 32'd0;
            7:  r = (ua < ub) ? 32'd1 : 32'd0;
            8:  r = 32'((ua * (64'd1 << s)) % 64'h1_0000_0000);
            9:  r = 32'(ua / (64'd1 << s));
            10: r = (a[31] && s != 0) ? (32'(ua / (64'd1 << s)) | ~(32'hFFFF_FFFF >> s))
                                      : 32'(ua / (64'd1 << s));
            11: r = 32'((ub * 65536) % 64'h1_0000_0000);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_op_b();
        logic [31:0] imm;
        if (use_shamt) return {27'd0, shamt};
        imm = is_unsigned ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};
        return alu_src ? imm : rt_data;
    endfunction

    task automatic apply(input logic v, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [4:0] sh, input logic src,
                         input logic uns, input logic ush, input logic [3:0] op);
        in_valid = v; rs_data = rs; rt_data = rt; imm16 = imm; shamt = sh;
        alu_src = src; is_unsigned = uns; use_shamt = ush; alu_op = op;
        exp_result = ref_alu(int'(op), rs, ref_op_b());
        exp_valid  = v;
    endtask

    task automatic check_pc(input string tag);
        int off;
        off = $signed(imm16);
        #1;
        check_eq({tag, ".pc4"}, pc_incremented, pc + 32'd4);
        check_eq({tag, ".bt"}, branch_target, pc + 32'd4 + 32'(off * 4));
    endtask

    // Wait for the capturing edge, check registered outputs, return to the next negedge.
    task automatic step_check(input string tag);
        @(posedge clk);
        #1;
        check_eq({tag, ".res"}, result_q, exp_result);
        check_eq({tag, ".zero"}, {31'd0, zero_q}, {31'd0, exp_result == 32'd0});
        check_eq({tag, ".neg"}, {31'd0, negative_q}, {31'd0, exp_result[31]});
        check_eq({tag, ".vld"}, {31'd0, out_valid}, {31'd0, exp_valid});
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".res"}, result_q, 32'd0);
        check_eq({tag, ".zero"}, {31'd0, zero_q}, 32'd0);
        check_eq({tag, ".neg"}, {31'd0, negative_q}, 32'd0);
        check_eq({tag, ".vld"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_b = 1'b1;
        pc    = 32'h0;
        apply(1'b0, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");

        @(negedge clk);
        rst_b = 1'b0;
        apply(1'b1, 32'd5, 32'd7, 16'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        check_eq("add.model", exp_result, 32'd12);
        step_check("add");

        apply(1'b1, 32'd3, 32'd5, 16'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd1);
        check_eq("sub.model", exp_result, 32'hFFFF_FFFE);
        step_check("sub_neg");
        apply(1'b1, 32'd9, 32'd9, 16'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd1);
        step_check("sub_zero");

        apply(1'b1, 32'd0, 32'd0, 16'hFFFF, 5'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        check_eq("immS.model", exp_result, 32'hFFFF_FFFF);
        step_check("imm_sext");
        apply(1'b1, 32'd0, 32'd0, 16'hFFFF, 5'd0, 1'b1, 1'b1, 1'b0, 4'd0);
        check_eq("immU.model", exp_result, 32'h0000_FFFF);
        step_check("imm_zext");

        apply(1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 16'd0, 5'd4, 1'b1, 1'b0, 1'b1, 4'd8);
        check_eq("sll.model", exp_result, 32'h0000_0010);
        step_check("sll");
        apply(1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 16'd0, 5'd4, 1'b0, 1'b0, 1'b1, 4'd9);
        check_eq("srl.model", exp_result, 32'h0800_0000);
        step_check("srl");
        apply(1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 16'd0, 5'd4, 1'b0, 1'b0, 1'b1, 4'd10);
        check_eq("sra.model", exp_result, 32'hF800_0000);
        step_check("sra");

        pc = 32'h100;
        imm16 = 16'hFFFF;
        #1;
        check_eq("pc.inc", pc_incremented, 32'h104);
        check_eq("pc.bt_neg", branch_target, 32'h100);
        imm16 = 16'h0003;
        is_unsigned = 1'b1;
        #1;
        check_eq("pc.bt_pos", branch_target, 32'h110);
        @(negedge clk);

        // Mid-stream reset with a nonzero valid result held in the registers.
        apply(1'b1, 32'h1234_0000, 32'h0000_5678, 16'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd3);
        step_check("pre_rst");
        apply(1'b1, 32'd40, 32'd2, 16'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        #2;
        rst_b = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check_reset_state("held_rst");
        @(negedge clk);
        rst_b = 1'b0;
        apply(1'b1, 32'hFFFF_FFF0, 32'd1, 16'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd6);
        step_check("post_rst");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            pc = $urandom;
            apply(1'($urandom), a, b, 16'($urandom), 5'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
            check_pc("rnd");
            step_check($sformatf("rnd%0d_op%0d", i, alu_op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Single-cycle execute block for the 32-bit MIPS-style core. It selects the ALU second operand, computes the ALU result and flags, and registers them with a one-cycle latency. It also computes the sequential PC and branch target combinationally. It sits between the register file/decoder and the memory/write-back muxing in the data path.

## Interface
Parameters:
- XLEN, 32: datapath width; only 32 is required to work.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_b  in  1  asynchronous, active-high reset (high = reset).
- in_valid  in  1  operands and controls valid this cycle.
- rs_data  in  XLEN  ALU first operand.
- rt_data  in  XLEN  register second operand.
- imm16  in  16  instruction immediate (inst[15:0]).
- shamt  in  5  shift amount (inst[10:6]).
- alu_src  in  1  0: rt_data, 1: extended immediate.
- is_unsigned  in  1  immediate extension: 0 sign, 1 zero.
- use_shamt  in  1  1: second operand = zero-extended shamt (overrides alu_src).
- alu_op  in  4  operation code.
- pc  in  XLEN  current PC.
- pc_incremented  out  XLEN  pc + 4, combinational.
- branch_target  out  XLEN  pc + 4 + (sign_ext(imm16) << 2), combinational.
- result_q  out  XLEN  registered ALU result.
- zero_q  out  1  registered (result == 0).
- negative_q  out  1  registered result[31].
- out_valid  out  1  registered in_valid.

## Operation
- Immediate: is_unsigned=0 → {16{imm16[15]}, imm16}; is_unsigned=1 → {16'b0, imm16}.
- Operand B: use_shamt=1 → {27'b0, shamt}; otherwise alu_src ? immediate : rt_data.
- Operand A is always rs_data.
- Opcodes:
  - 0 ADD: A+B, wraps modulo 2^32, no overflow trap.
  - 1 SUB: A−B, wraps.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOR.
  - 6 SLT: signed A<B → 1, else 0.
  - 7 SLTU: unsigned compare → 1, else 0.
  - 8 SLL: A << B[4:0].
  - 9 SRL: logical A >> B[4:0].
  - 10 SRA: arithmetic A >>> B[4:0].
  - 11 LUI: B << 16.
  - 12–15: reserved; result 0.
- Shift amounts use only B[4:0]; upper bits are ignored.
- Flags are derived from the 32-bit result: zero = (result == 0), negative = result[31].
- pc_incremented and branch_target use wrapping 32-bit adds. The branch offset always uses sign extension, regardless of is_unsigned.

## Timing
- Combinational paths: pc → pc_incremented and branch_target; all operand and control inputs → internal result.
- Registered paths: result_q, zero_q, negative_q and out_valid capture on every rising clk edge. Latency is one cycle.
- Registers load every cycle regardless of in_valid. out_valid qualifies them.
- Reset: while rst_b is high, result_q=0, zero_q=0, negative_q=0, out_valid=0, asynchronously and immediately. Combinational outputs still follow pc.
- Reset mid-operation discards the pending result. The first capture happens on the first rising edge after rst_b falls.
- No handshake back-pressure; back-to-back valid cycles are supported at full rate.

## Structure
- Shared package exec_pkg: XLEN, the alu_op enum (ADD…LUI, reserved codes), and a shamt width constant (5).
- Sub-module alu_core: purely combinational (A, B, alu_op) → (result, zero, negative).
- Operand muxing, both PC adders and the output registers live in exec_unit.

## Test plan
- ADD: rs=5, rt=7, alu_src=0, op=0 → next cycle result_q=12, zero_q=0, negative_q=0, out_valid=1.
- SUB: rs=3, rt=5, op=1 → result_q=0xFFFFFFFE, negative_q=1. Then rs=rt=9 → result_q=0, zero_q=1.
- Immediate extension: rs=0, imm16=0xFFFF, alu_src=1, op=0.
  - is_unsigned=0 → result_q=0xFFFFFFFF.
  - is_unsigned=1 → result_q=0x0000FFFF.
- Shifts: rs=0x80000001, use_shamt=1, shamt=4.
  - SLL → 0x00000010.
  - SRL → 0x08000000.
  - SRA → 0xF8000000.
- PC adders: pc=0x100.
  - imm16=0xFFFF → pc_incremented=0x104, branch_target=0x100.
  - imm16=0x0003 → branch_target=0x110.
- Reset: assert rst_b mid-stream with in_valid=1 → all registered outputs 0 immediately, without waiting for a clock edge. After release, the first edge captures the current inputs.
